// File: rtl/altrom_cpu_master.sv
// altrom_cpu_master: CPU-side initiator for the 24 KB ALTROM CPU port (word window 0x00000-0x017FF).
// Latency: write ack T+2, read miss T+3, read hit / address error T+1 (T = accept cycle).
// Backpressure: req_ready is high only in IDLE; the response channel has none (one-cycle rsp_valid pulse).
//
// Ports:
//   baseck, cpuresetb                     clock (rising edge), async active-low reset
//   req_valid/req_ready/req_wr/req_addr/req_wdata   core request channel
//   rsp_valid/rsp_data/rsp_err            response pulse; data and err held until the next response
//   pf_flush                              invalidate the prefetch buffer
//   cpu_ad/cpu_di/cpu_en/cpu_wr/cpu_do    ALTROM CPU port; cpu_do is valid the cycle after cpu_en
//
// Optional feature: define ALTROM_PREFETCH_EN to build the one-word sequential prefetch buffer.

module altrom_cpu_master (
  input  logic        baseck,
  input  logic        cpuresetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        pf_flush,
  output logic [17:0] cpu_ad,
  output logic [31:0] cpu_di,
  output logic        cpu_en,
  output logic        cpu_wr,
  input  logic [31:0] cpu_do
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_CAP    = 3'd2
`ifdef ALTROM_PREFETCH_EN
    ,
    ST_PF_ACC = 3'd3,
    ST_PF_CAP = 3'd4
`endif
  } state_t;

  // 12 banks of 512 words: upper bits zero and bank index 0..11.
  function automatic logic in_window(input logic [17:0] a);
    return (a[17:13] == 5'd0) && (a[12:9] <= 4'd11);
  endfunction

  state_t      state_q, state_d;
  logic [17:0] cpu_ad_q, cpu_ad_d;
  logic [31:0] cpu_di_q, cpu_di_d;
  logic        cpu_en_q, cpu_en_d;
  logic        cpu_wr_q, cpu_wr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;

`ifdef ALTROM_PREFETCH_EN
  logic        pf_valid_q, pf_valid_d;
  logic [17:0] pf_tag_q, pf_tag_d;
  logic [31:0] pf_data_q, pf_data_d;
  logic [17:0] ad_inc;
  logic [17:0] tag_inc;
  logic        pf_hit;

  assign ad_inc  = cpu_ad_q + 18'd1;
  assign tag_inc = pf_tag_q + 18'd1;
  // A flush in the accept cycle suppresses the hit so stale data is never returned.
  assign pf_hit  = pf_valid_q && !pf_flush && (pf_tag_q == req_addr);
`else
  logic unused_pf_flush;
  assign unused_pf_flush = pf_flush;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cpu_ad_d    = cpu_ad_q;
    cpu_di_d    = cpu_di_q;
    cpu_wr_d    = cpu_wr_q;
    cpu_en_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALTROM_PREFETCH_EN
    pf_valid_d  = pf_valid_q;
    pf_tag_d    = pf_tag_q;
    pf_data_d   = pf_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!in_window(req_addr)) begin
            // Error: answer next cycle, ALTROM port untouched.
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_err_d   = 1'b1;
          end else if (req_wr) begin
            state_d  = ST_ACC;
            cpu_en_d = 1'b1;
            cpu_ad_d = req_addr;
            cpu_di_d = req_wdata;
            cpu_wr_d = 1'b1;
`ifdef ALTROM_PREFETCH_EN
            // Keep the buffered word coherent with the write.
            if (pf_valid_q && (pf_tag_q == req_addr)) begin
              pf_data_d = req_wdata;
            end
`endif
          end
`ifdef ALTROM_PREFETCH_EN
          else if (pf_hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = pf_data_q;
            rsp_err_d   = 1'b0;
            // Run ahead one word so a sequential stream keeps hitting.
            if (in_window(tag_inc)) begin
              state_d  = ST_PF_ACC;
              cpu_en_d = 1'b1;
              cpu_ad_d = tag_inc;
              cpu_wr_d = 1'b0;
            end
          end
`endif
          else begin
            state_d  = ST_ACC;
            cpu_en_d = 1'b1;
            cpu_ad_d = req_addr;
            cpu_wr_d = 1'b0;
          end
        end
      end

      ST_ACC: begin
        if (cpu_wr_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = ST_CAP;
        end
      end

      ST_CAP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = cpu_do;
        rsp_err_d   = 1'b0;
`ifdef ALTROM_PREFETCH_EN
        if (in_window(ad_inc)) begin
          state_d  = ST_PF_ACC;
          cpu_en_d = 1'b1;
          cpu_ad_d = ad_inc;
        end
`endif
      end

`ifdef ALTROM_PREFETCH_EN
      ST_PF_ACC: begin
        state_d = ST_PF_CAP;
      end

      ST_PF_CAP: begin
        // cpu_ad still holds the prefetched address and serves as the tag.
        state_d    = ST_IDLE;
        pf_valid_d = 1'b1;
        pf_tag_d   = cpu_ad_q;
        pf_data_d  = cpu_do;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef ALTROM_PREFETCH_EN
    // Applied last so a flush coinciding with the fill wins.
    if (pf_flush) begin
      pf_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge baseck or negedge cpuresetb) begin
    if (!cpuresetb) begin
      state_q     <= ST_IDLE;
      cpu_ad_q    <= 18'd0;
      cpu_di_q    <= 32'd0;
      cpu_en_q    <= 1'b0;
      cpu_wr_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_ad_q    <= cpu_ad_d;
      cpu_di_q    <= cpu_di_d;
      cpu_en_q    <= cpu_en_d;
      cpu_wr_q    <= cpu_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef ALTROM_PREFETCH_EN
  always_ff @(posedge baseck or negedge cpuresetb) begin
    if (!cpuresetb) begin
      pf_valid_q <= 1'b0;
      pf_tag_q   <= 18'd0;
      pf_data_q  <= 32'd0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_tag_q   <= pf_tag_d;
      pf_data_q  <= pf_data_d;
    end
  end
`endif

  assign cpu_ad    = cpu_ad_q;
  assign cpu_di    = cpu_di_q;
  assign cpu_en    = cpu_en_q;
  assign cpu_wr    = cpu_wr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
